// File: rtl/b1to8_deserializer_if.sv
// Handshake bundle for the bit-serial receiver: serial bit stream in, parallel words out.
interface b1to8_deserializer_if #(
    parameter int W = 8
);
    logic         x0;
    logic         x_valid;
    logic         x_ready;
    logic [W-1:0] z7_z0;
    logic         z_valid;
    logic         z_ready;

    modport master (
        output x0, x_valid, z_ready,
        input  x_ready, z7_z0, z_valid
    );

    modport slave (
        input  x0, x_valid, z_ready,
        output x_ready, z7_z0, z_valid
    );
endinterface

// File: rtl/b1to8_deserializer.sv
// Serial-to-parallel receiver: demuxes accepted bits into a shift register by index,
// then hands each complete word to a one-word output buffer.
//
// state   | meaning
// COLLECT | accepting bits into the shift register (x_ready=1)
// HOLD    | full word parked in the shift register, waiting for the buffer to drain
module b1to8_deserializer #(
    parameter int W     = 8,
    parameter int CW    = 3,
    parameter bit MSB_1 = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_,
    input  logic                  clear,
    b1to8_deserializer_if.slave   bus,
    output logic [CW-1:0]         b2_b0
);
    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  shreg;
    logic [W-1:0]  next_word;
    logic [CW-1:0] slot;
    logic          accept;
    logic          consume;

    assign accept  = bus.x_valid & bus.x_ready;
    assign consume = bus.z_valid & bus.z_ready;
    assign slot    = MSB_1 ? (LAST - b2_b0) : b2_b0;

    // Shift register with the incoming bit already placed, so a finishing word can load directly.
    always_comb begin
        next_word       = shreg;
        next_word[slot] = bus.x0;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state       <= COLLECT;
            bus.x_ready <= 1'b1;
            b2_b0       <= '0;
            shreg       <= '0;
            bus.z7_z0   <= '0;
            bus.z_valid <= 1'b0;
        end else begin
            if (consume)
                bus.z_valid <= 1'b0;
            // Abort only touches the collecting side; the output buffer carries on.
            if (clear) begin
                b2_b0       <= '0;
                shreg       <= '0;
                state       <= COLLECT;
                bus.x_ready <= 1'b1;
            end else begin
                case (state)
                    COLLECT: begin
                        if (accept) begin
                            shreg <= next_word;
                            b2_b0 <= b2_b0 + CW'(1);
                            if (b2_b0 == LAST) begin
                                if (!bus.z_valid || bus.z_ready) begin
                                    bus.z7_z0   <= next_word;
                                    bus.z_valid <= 1'b1;
                                end else begin
                                    state       <= HOLD;
                                    bus.x_ready <= 1'b0;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (consume) begin
                            bus.z7_z0   <= shreg;
                            bus.z_valid <= 1'b1;
                            state       <= COLLECT;
                            bus.x_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= COLLECT;
                        bus.x_ready <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_b1to8_deserializer.sv
// Scoreboard bench: a word-level model predicts completed words and handshake state,
// a negedge monitor compares every cycle and pops expected words on each consume.
module tb_b1to8_deserializer;
    localparam int W  = 8;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset_;
    logic          clear;
    logic          clear2;
    logic [CW-1:0] b2_b0;
    logic [CW-1:0] b2_b0_2;

    always #5 clock = ~clock;

    b1to8_deserializer_if #(.W(W)) bus  ();
    b1to8_deserializer_if #(.W(W)) bus2 ();

    b1to8_deserializer #(.W(W), .CW(CW), .MSB_1(1'b0)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .clear  (clear),
        .bus    (bus),
        .b2_b0  (b2_b0)
    );

    b1to8_deserializer #(.W(W), .CW(CW), .MSB_1(1'b1)) dut_msb (
        .clock  (clock),
        .reset_ (reset_),
        .clear  (clear2),
        .bus    (bus2),
        .b2_b0  (b2_b0_2)
    );

    int errors = 0;
    int checks = 0;

    // Model: bits received so far of the current word, words owed to the output side.
    bit           q_bits[$];
    logic [W-1:0] expq[$];
    int           m_pending;
    bit           m_held;
    logic [W-1:0] m_zdata;
    logic [W-1:0] m_held_word;

    int  cyc = 0;
    bit  rec = 1'b0;
    int  vcyc[$];

    logic         cons, acc;
    logic [W-1:0] w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input bit b[$], input bit msb_first);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (msb_first) r[W-1-i] = b[i];
            else           r[i]     = b[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        q_bits.delete();
        expq.delete();
        m_pending   = 0;
        m_held      = 1'b0;
        m_zdata     = '0;
        m_held_word = '0;
    endtask

    always @(negedge clock) begin
        if (reset_) begin
            chk("x_ready", 32'(bus.x_ready), 32'(!m_held));
            chk("z_valid", 32'(bus.z_valid), 32'(m_pending > 0));
            chk("b2_b0",   32'(b2_b0),       32'(q_bits.size()));
            chk("z7_z0",   32'(bus.z7_z0),   32'(m_zdata));
            cyc++;
            if (rec && bus.z_valid) vcyc.push_back(cyc);

            cons = (m_pending > 0) && bus.z_ready;
            acc  = bus.x_valid && !m_held;
            if (cons) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: consume of %0h with nothing expected", bus.z7_z0);
                end else begin
                    w = expq.pop_front();
                    chk("scoreboard", 32'(bus.z7_z0), 32'(w));
                end
                m_pending--;
            end
            if (clear) begin
                if (m_held) begin
                    m_held = 1'b0;
                    m_pending--;
                    void'(expq.pop_back());
                end
                q_bits.delete();
            end else if (m_held) begin
                if (cons) begin
                    m_held  = 1'b0;
                    m_zdata = m_held_word;
                end
            end else if (acc) begin
                q_bits.push_back(bus.x0);
                if (q_bits.size() == W) begin
                    w = pack(q_bits, 1'b0);
                    q_bits.delete();
                    expq.push_back(w);
                    if (m_pending > 0) begin
                        m_held      = 1'b1;
                        m_held_word = w;
                    end else begin
                        m_zdata = w;
                    end
                    m_pending++;
                end
            end
        end
    end

    // Inputs change just after a rising edge and hold until the next one.
    task automatic step(input bit v, input bit b, input bit zr, input bit clr);
        @(posedge clock);
        #1;
        bus.x_valid = v;
        bus.x0      = b;
        bus.z_ready = zr;
        clear       = clr;
    endtask

    task automatic send_byte(input logic [7:0] val, input bit zr);
        for (int i = 0; i < 8; i++) step(1'b1, val[i], zr, 1'b0);
    endtask

    task automatic step2(input bit v, input bit b);
        @(posedge clock);
        #1;
        bus2.x_valid = v;
        bus2.x0      = b;
    endtask

    logic [7:0] rb;
    logic [7:0] exp_msb;
    bit         bq[$];

    initial begin
        reset_       = 1'b0;
        clear        = 1'b0;
        clear2       = 1'b0;
        bus.x0       = 1'b0;
        bus.x_valid  = 1'b0;
        bus.z_ready  = 1'b0;
        bus2.x0      = 1'b0;
        bus2.x_valid = 1'b0;
        bus2.z_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset_ = 1'b1;

        // LSB-first word 8'h4D with a single-cycle valid pulse
        send_byte(8'h4D, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        chk("t2_valid", 32'(bus.z_valid), 32'd1);
        chk("t2_word",  32'(bus.z7_z0),   32'h4D);
        @(negedge clock);
        chk("t2_pulse", 32'(bus.z_valid), 32'd0);

        // Asynchronous reset mid-word, observed with no clock edge
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #2 reset_ = 1'b0;
        #1;
        chk("t1_b2_b0",   32'(b2_b0),       32'd0);
        chk("t1_z7_z0",   32'(bus.z7_z0),   32'd0);
        chk("t1_z_valid", 32'(bus.z_valid), 32'd0);
        chk("t1_x_ready", 32'(bus.x_ready), 32'd1);
        model_reset();
        bus.x_valid = 1'b0;
        #1 reset_ = 1'b1;

        // Backpressure: second word parks in HOLD until the buffer drains
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("t3_hold_ready", 32'(bus.x_ready), 32'd0);
        chk("t3_hold_word",  32'(bus.z7_z0),   32'hA5);
        chk("t3_hold_valid", 32'(bus.z_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("t3_next_word",  32'(bus.z7_z0),   32'h3C);
        chk("t3_next_valid", 32'(bus.z_valid), 32'd1);
        chk("t3_next_ready", 32'(bus.x_ready), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Streaming: 64 accepts -> 8 words, valid pulses 8 cycles apart
        vcyc.delete();
        rec = 1'b1;
        for (int i = 0; i < 64; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        rec = 1'b0;
        chk("t4_words", 32'(vcyc.size()), 32'd8);
        for (int i = 1; i < vcyc.size(); i++)
            chk("t4_spacing", 32'(vcyc[i] - vcyc[i-1]), 32'd8);

        // clear together with a valid bit drops the partial word and that bit
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        chk("t5_b2_b0", 32'(b2_b0), 32'd0);
        rb = 8'($urandom);
        send_byte(rb, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        chk("t5_valid", 32'(bus.z_valid), 32'd1);
        chk("t5_word",  32'(bus.z7_z0),   32'(rb));

        // Random traffic with backpressure and occasional clears
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        chk("drain_empty", 32'(expq.size()), 32'd0);

        // MSB-first instance: first bit lands in the top slot
        step2(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step2(1'b1, 1'b0);
        step2(1'b0, 1'b0);
        @(negedge clock);
        chk("t6_valid", 32'(bus2.z_valid), 32'd1);
        chk("t6_word",  32'(bus2.z7_z0),   32'h80);
        chk("t6_b2_b0", 32'(b2_b0_2),      32'd0);
        rb = 8'($urandom);
        bq.delete();
        for (int i = 0; i < 8; i++) begin
            bq.push_back(rb[i]);
            step2(1'b1, rb[i]);
        end
        exp_msb = pack(bq, 1'b1);
        step2(1'b0, 1'b0);
        @(negedge clock);
        chk("t6_rand_word", 32'(bus2.z7_z0), 32'(exp_msb));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
